// File: rtl/rk192_store.sv
// -----------------------------------------------------------------------------
// rk192_store
// Round-key store between the AES-192 key expander and the cipher round
// engine. Captures the 13 round keys emitted by the expander (one 128-bit word
// per load-enable pulse, tagged with its round index) and replays them to the
// round engine, one word per clock, on request.
//
// Optional feature macro: RK192_STORE_DEC_EN
//   defined   : rd_dec port exists; rd_dec=1 sampled with rd_start replays 12->0
//   undefined : no rd_dec port; replay is always 0->12
//
// Ports
//   mclk        in   system clock, rising edge
//   arst_n      in   asynchronous active-low reset
//   rk192       in   [0:127] round key from the expander
//   rk192_count in   [3:0]   round index of rk192
//   rk192_le    in   load enable for rk192/rk192_count
//   kexp_busy   in   expander busy flag
//   rd_start    in   one-cycle replay request
//   rd_dec      in   replay order (only with RK192_STORE_DEC_EN)
//   rk_out      out  [0:127] replayed round key
//   rk_round    out  [3:0]   index of rk_out
//   rk_valid    out  rk_out/rk_round valid
//   keys_ready  out  all slots loaded and expander idle
//   rd_busy     out  replay in progress
//   err         out  sticky: load with index > 12 seen
// -----------------------------------------------------------------------------
module rk192_store #(
    parameter int NRK = 13
) (
    input  logic         mclk,
    input  logic         arst_n,
    input  logic [0:127] rk192,
    input  logic [3:0]   rk192_count,
    input  logic         rk192_le,
    input  logic         kexp_busy,
    input  logic         rd_start,
`ifdef RK192_STORE_DEC_EN
    input  logic         rd_dec,
`endif
    output logic [0:127] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    output logic         keys_ready,
    output logic         rd_busy,
    output logic         err
);

    localparam logic [3:0] LAST_IDX = 4'(NRK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [0:127]   mem_q [NRK];
    logic [NRK-1:0] mask_q, mask_d;
    logic [3:0]     idx_q, idx_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           dir_q, dir_d;
    logic [0:127]   rk_out_q, rk_out_d;
    logic [3:0]     rk_round_q, rk_round_d;
    logic           rk_valid_q, rk_valid_d;
    logic           keys_ready_q, keys_ready_d;
    logic           err_q, err_d;

    logic           wr_ok_s;
    logic           wr_bad_s;
    logic           new_key_s;
    logic           dec_s;
    logic [NRK-1:0] wr_onehot_s;

    assign wr_ok_s     = rk192_le && (rk192_count <= LAST_IDX);
    assign wr_bad_s    = rk192_le && (rk192_count >  LAST_IDX);
    // An index-0 load marks the start of a fresh key schedule.
    assign new_key_s   = rk192_le && (rk192_count == 4'd0);
    assign wr_onehot_s = {{(NRK-1){1'b0}}, 1'b1} << rk192_count;

`ifdef RK192_STORE_DEC_EN
    assign dec_s = rd_dec;
`else
    assign dec_s = 1'b0;
`endif

    assign rk_out     = rk_out_q;
    assign rk_round   = rk_round_q;
    assign rk_valid   = rk_valid_q;
    assign rd_busy    = rk_valid_q;
    assign keys_ready = keys_ready_q;
    assign err        = err_q;

    // Written-mask update: a new key restarts the mask with only slot 0 set.
    always_comb begin
        mask_d = mask_q;
        if (new_key_s) begin
            mask_d = {{(NRK-1){1'b0}}, 1'b1};
        end else if (wr_ok_s) begin
            mask_d = mask_q | wr_onehot_s;
        end else begin
            mask_d = mask_q;
        end
    end

    // Control FSM next state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        rk_out_d   = rk_out_q;
        rk_round_d = rk_round_q;
        rk_valid_d = 1'b0;
        err_d      = err_q | wr_bad_s;
        if (new_key_s) begin
            // Restarting the schedule wins over everything, including replay.
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    if ((&mask_q) && !kexp_busy) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_READY: begin
                    if (rd_start) begin
                        state_d = ST_READ;
                        dir_d   = dec_s;
                        idx_d   = dec_s ? LAST_IDX : 4'd0;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_READ: begin
                    rk_out_d   = mem_q[idx_q];
                    rk_round_d = idx_q;
                    rk_valid_d = 1'b1;
                    idx_d      = dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
                    cnt_d      = cnt_q + 4'd1;
                    // Leaving on the last word lets a new request land in the
                    // very next cycle, giving the 14-cycle repeat period.
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_READ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        keys_ready_d = (state_d == ST_READY) || (state_d == ST_READ);
    end

    // Round-key storage; out-of-range indices never reach the array.
    always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < NRK; k++) begin
                mem_q[k] <= {128{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_q[rk192_count] <= rk192;
        end
    end

    // Control state and output registers.
    always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            mask_q       <= {NRK{1'b0}};
            idx_q        <= 4'd0;
            cnt_q        <= 4'd0;
            dir_q        <= 1'b0;
            rk_out_q     <= {128{1'b0}};
            rk_round_q   <= 4'd0;
            rk_valid_q   <= 1'b0;
            keys_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            rk_out_q     <= rk_out_d;
            rk_round_q   <= rk_round_d;
            rk_valid_q   <= rk_valid_d;
            keys_ready_q <= keys_ready_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_rk192_store.sv
// -----------------------------------------------------------------------------
// tb_rk192_store
// Directed bench for rk192_store. The bench plays the AES-192 key expander for
// the FIPS-197 key, computing the 13 round keys itself, and checks replay
// order/timing, stall handling, error flag, abort, request collisions and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_rk192_store;

    logic         mclk;
    logic         arst_n;
    logic [0:127] rk192;
    logic [3:0]   rk192_count;
    logic         rk192_le;
    logic         kexp_busy;
    logic         rd_start;
`ifdef RK192_STORE_DEC_EN
    logic         rd_dec;
`endif
    logic [0:127] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         keys_ready;
    logic         rd_busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [127:0] keys [13];
    logic [31:0]  w [52];
    logic [31:0]  t;
    logic [7:0]   rcon;

    rk192_store #(.NRK(13)) dut (
        .mclk        (mclk),
        .arst_n      (arst_n),
        .rk192       (rk192),
        .rk192_count (rk192_count),
        .rk192_le    (rk192_le),
        .kexp_busy   (kexp_busy),
        .rd_start    (rd_start),
`ifdef RK192_STORE_DEC_EN
        .rd_dec      (rd_dec),
`endif
        .rk_out      (rk_out),
        .rk_round    (rk_round),
        .rk_valid    (rk_valid),
        .keys_ready  (keys_ready),
        .rd_busy     (rd_busy),
        .err         (err)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // ---------------- AES-192 key expansion model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] v);
        return {sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0]), sbox(v[31:24])};
    endfunction

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_range(input int lo, input int hi, input logic busy);
        for (int r = lo; r <= hi; r++) begin
            rk192       = keys[r];
            rk192_count = 4'(r);
            rk192_le    = 1'b1;
            kexp_busy   = busy;
            tick;
        end
        rk192_le = 1'b0;
    endtask

    // Issues rd_start at the next edge and checks the 13-word burst that
    // follows; returns right after the last word so a new request can be
    // issued back-to-back.
    task automatic replay(input logic dec);
        int idx;
`ifdef RK192_STORE_DEC_EN
        rd_dec = dec;
`endif
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        chk("valid_before_first", 128'(rk_valid), 128'd0);
        for (int i = 0; i < 13; i++) begin
            tick;
            idx = dec ? (12 - i) : i;
            chk("rk_valid", 128'(rk_valid), 128'd1);
            chk("rd_busy", 128'(rd_busy), 128'd1);
            chk("rk_round", 128'(rk_round), 128'(idx));
            chk("rk_out", rk_out, keys[idx]);
            if (idx == 0)  chk("fips_w0",  rk_out, 128'h8E73B0F7DA0E6452C810F32B809079E5);
            if (idx == 1)  chk("fips_w1",  rk_out, 128'h62F8EAD2522C6B7BFE0C91F72402F5A5);
            if (idx == 12) chk("fips_w12", rk_out, 128'hE98BA06F448C773C8ECC720401002202);
        end
    endtask

    initial begin
        // Expander model: FIPS-197 AES-192 key.
        w[0] = 32'h8e73b0f7; w[1] = 32'hda0e6452; w[2] = 32'hc810f32b;
        w[3] = 32'h809079e5; w[4] = 32'h62f8ead2; w[5] = 32'h522c6b7b;
        rcon = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t    = subrot(t) ^ {rcon, 24'h000000};
                rcon = xt(rcon);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        arst_n      = 1'b0;
        rk192       = 128'd0;
        rk192_count = 4'd0;
        rk192_le    = 1'b0;
        kexp_busy   = 1'b0;
        rd_start    = 1'b0;
`ifdef RK192_STORE_DEC_EN
        rd_dec      = 1'b0;
`endif
        @(negedge mclk);
        chk("rst_rk_out", rk_out, 128'd0);
        chk("rst_rk_round", 128'(rk_round), 128'd0);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_keys_ready", 128'(keys_ready), 128'd0);
        chk("rst_rd_busy", 128'(rd_busy), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        @(negedge mclk);
        arst_n = 1'b1;
        tick;

        // Stall: all loads done but expander still busy.
        load_range(0, 12, 1'b1);
        tick;
        tick;
        chk("stall_keys_ready", 128'(keys_ready), 128'd0);
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        tick;
        chk("stall_rd_ignored", 128'(rk_valid), 128'd0);
        chk("stall_keys_ready2", 128'(keys_ready), 128'd0);
        kexp_busy = 1'b0;
        tick;
        chk("release_keys_ready", 128'(keys_ready), 128'd1);

        // Two bursts, second request 14 cycles after the first.
        replay(1'b0);
        replay(1'b0);
        tick;
        chk("post_burst_valid", 128'(rk_valid), 128'd0);
        chk("post_burst_busy", 128'(rd_busy), 128'd0);
        chk("hold_rk_out", rk_out, keys[12]);
        chk("hold_rk_round", 128'(rk_round), 128'd12);
        chk("post_burst_ready", 128'(keys_ready), 128'd1);

`ifdef RK192_STORE_DEC_EN
        replay(1'b1);
        tick;
        chk("dec_hold_round", 128'(rk_round), 128'd0);
`endif

        // Out-of-range index: discarded, sticky err.
        rk192       = {16{8'hAA}};
        rk192_count = 4'd13;
        rk192_le    = 1'b1;
        tick;
        rk192_le = 1'b0;
        chk("err_set", 128'(err), 128'd1);
        tick;
        tick;
        chk("err_sticky", 128'(err), 128'd1);
        chk("err_ready_kept", 128'(keys_ready), 128'd1);
        replay(1'b0);
        tick;
        chk("err_after_replay", 128'(err), 128'd1);

        // Abort: index-0 load while word 5 is being presented.
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("abort_pre_round", 128'(rk_round), 128'(i));
        end
        rk192       = keys[0];
        rk192_count = 4'd0;
        rk192_le    = 1'b1;
        tick;
        rk192_le = 1'b0;
        chk("abort_valid", 128'(rk_valid), 128'd0);
        chk("abort_busy", 128'(rd_busy), 128'd0);
        chk("abort_ready", 128'(keys_ready), 128'd0);
        chk("abort_hold_out", rk_out, keys[5]);
        chk("abort_hold_round", 128'(rk_round), 128'd5);
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        tick;
        chk("abort_rd_ignored", 128'(rk_valid), 128'd0);
        load_range(1, 11, 1'b0);
        tick;
        chk("abort_partial_ready", 128'(keys_ready), 128'd0);
        load_range(12, 12, 1'b0);
        chk("abort_last_edge_ready", 128'(keys_ready), 128'd0);
        tick;
        chk("abort_reload_ready", 128'(keys_ready), 128'd1);
        replay(1'b0);
        tick;

        // Index-0 load collides with rd_start in READY: load wins.
        rd_start    = 1'b1;
        rk192       = keys[0];
        rk192_count = 4'd0;
        rk192_le    = 1'b1;
        tick;
        rd_start = 1'b0;
        rk192_le = 1'b0;
        chk("collide_ready", 128'(keys_ready), 128'd0);
        tick;
        chk("collide_valid", 128'(rk_valid), 128'd0);
        load_range(1, 12, 1'b0);
        tick;
        chk("collide_reload_ready", 128'(keys_ready), 128'd1);

        // Asynchronous reset in the middle of a replay.
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        tick;
        tick;
        tick;
        chk("pre_reset_valid", 128'(rk_valid), 128'd1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_rk_out", rk_out, 128'd0);
        chk("arst_rk_round", 128'(rk_round), 128'd0);
        chk("arst_rk_valid", 128'(rk_valid), 128'd0);
        chk("arst_keys_ready", 128'(keys_ready), 128'd0);
        chk("arst_rd_busy", 128'(rd_busy), 128'd0);
        chk("arst_err", 128'(err), 128'd0);
        @(negedge mclk);
        arst_n = 1'b1;
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick;
            chk("post_reset_no_valid", 128'(rk_valid), 128'd0);
        end
        chk("post_reset_ready", 128'(keys_ready), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rk192_store.md
# rk192_store

Round-key store for the AES-192 datapath. Sits between the AES-192 key expander and the cipher round engine. It captures the 13 round keys the expander emits (one 128-bit word per load-enable pulse, tagged with its round index), then replays them to the round engine one per clock on request.

## Interface
Parameters:
- NRK, 13, number of round keys stored (indices 0..12).

Ports:
- mclk  in  1  system clock; all logic is rising-edge.
- arst_n  in  1  asynchronous, active-low reset.
- rk192  in  [0:127]  round key from the expander.
- rk192_count  in  [3:0]  round index of rk192.
- rk192_le  in  1  load enable; rk192 and rk192_count are valid this cycle.
- kexp_busy  in  1  expander busy flag.
- rd_start  in  1  one-cycle pulse that requests a replay of all round keys.
- rd_dec  in  1  replay order: 0 = 0→12, 1 = 12→0. Present only with the macro in Configuration.
- rk_out  out  [0:127]  replayed round key.
- rk_round  out  [3:0]  index of rk_out.
- rk_valid  out  1  rk_out/rk_round are valid.
- keys_ready  out  1  all 13 slots are loaded and the expander is idle.
- rd_busy  out  1  replay in progress.
- err  out  1  sticky flag: a load arrived with an index greater than 12.

## Operation
- Storage: 13×128-bit register file and a 13-bit written-mask.
- States:
  - IDLE: reset state; nothing is loaded.
  - LOAD: keys are being captured.
  - READY: all keys loaded; replay can start.
  - READ: replay in progress.
- Load path, valid in every state:
  - When rk192_le=1 and rk192_count≤12, write rk192 into slot rk192_count and set that mask bit.
  - When rk192_le=1 and rk192_count>12, discard the data and set err. err clears only on reset.
- New key:
  - rk192_le=1 with rk192_count=0 clears the mask, except for bit 0, which is set by the same write.
  - It also drops keys_ready and moves the FSM to LOAD.
  - This applies from IDLE, LOAD, READY and READ. In READ it aborts the replay.
- LOAD→READY: when the mask is all ones and kexp_busy=0. keys_ready=1 exactly while in READY or READ.
- READY→READ: on rd_start=1, provided no index-0 load occurs in the same cycle.
  - The replay start index is latched: 0 when ascending, 12 when descending.
- READ:
  - Each cycle presents one slot, then steps the index by +1 (ascending) or −1 (descending).
  - After the 13th word, the FSM returns to READY.
- rd_start is ignored outside READY, including during READ. It does not set err.
- Re-writing a slot with index ≠ 0 during READ updates storage. Whether the replay shows the old or new value depends only on whether that slot has already been presented.

## Timing
- Reset values:
  - rk_out = 0, rk_round = 0.
  - rk_valid, keys_ready, rd_busy and err = 0.
  - FSM = IDLE, mask = 0.
- Load latency: a word written at edge N can be replayed from edge N+1.
- keys_ready rises one cycle after the edge where the last mask bit is set and kexp_busy=0, or one cycle after kexp_busy falls, whichever is later.
- Replay timing:
  - rd_start is sampled at edge N.
  - Outputs are registered: rk_valid=1 with the first key after edge N+1, continuing through edge N+13.
  - rk_valid falls after edge N+14.
  - rd_busy equals rk_valid.
- Back-to-back replay: a new rd_start is accepted in the first READY cycle after the burst, so the minimum repeat period is 14 cycles.
- Abort: an index-0 load at edge M while in READ gives rk_valid=0 after edge M.
- Simultaneous events: an index-0 load in the same cycle as rd_start in READY wins. No replay starts.
- rk_out and rk_round hold their last values when rk_valid=0.

## Configuration
- RK192_STORE_DEC_EN:
  - Defined: the rd_dec port exists. rd_dec is sampled with rd_start and selects descending replay for the inverse cipher.
  - Undefined: the port is absent and replay is always ascending (0→12).

## Test plan
- FIPS-197 key 8E73B0F7DA0E6452C810F32B809079E562F8EAD2522C6B7B driven through the expander.
  - Required: keys_ready rises after the expander finishes.
  - rd_start replays 13 words. Word 0 = 8E73B0F7DA0E6452C810F32B809079E5, word 1 = 62F8EAD2522C6B7BFE0C91F72402F5A5, word 12 = E98BA06F448C773C8ECC720401002202.
  - rk_valid is high for exactly 13 cycles.
- With RK192_STORE_DEC_EN defined, the same key with rd_dec=1.
  - Required: first word E98BA06F…01002202 with rk_round=12, last word 8E73B0F7…809079E5 with rk_round=0.
- Load with rk192_count=13, data AAAA…AA.
  - Required: err=1 (sticky), no slot changed, and the replay still matches the FIPS-197 values.
- Index-0 load injected at replay word 5.
  - Required: rk_valid=0 on the next cycle, keys_ready=0, and the FSM stays in LOAD until all 13 slots are reloaded.
- Stall and request handling.
  - Hold kexp_busy=1 after all 13 loads: keys_ready stays 0 and rd_start is ignored.
  - Release kexp_busy: keys_ready=1 one cycle later.
  - Two rd_start pulses 14 cycles apart: two full bursts.
- Assert arst_n=0 mid-replay.
  - Required: all outputs are 0 immediately, and rd_start after reset produces no rk_valid until the keys are reloaded.
